fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the RV32I pipeline. It tracks the destination register of every instruction in flight from EX through the last forwarding stage in an internal shadow pipeline. From that state it produces per-operand bypass selects for the EX stage, load-use stall requests for ID, and a global freeze while data memory is busy. It generalises the existing EX/MEM–MEM/WB forwarding logic to N source operands, M forwarding stages and a configurable load-data stage, and adds a stall-cycle counter.

## Interface
Parameters:
- REG_AW, 5, register address width; address 0 is the hard-wired zero register.
- NUM_SRC, 2, source operands per instruction.
- FWD_STAGES, 2, number of forwarding stages after EX (stage 1 = EX/MEM, stage 2 = MEM/WB, ...); must be ≥ 1.
- LOAD_STAGE, 2, first stage whose entry holds load data; 1 ≤ LOAD_STAGE ≤ FWD_STAGES.
- CNT_W, 32, stall counter width.
- SEL_W (derived), clog2(FWD_STAGES+1), width of one forward select.

Ports:
- clk, in, 1, clock; one clock domain.
- rst_n, in, 1, reset, asynchronous, active-low.
- id_valid, in, 1, ID holds a real instruction.
- id_rs, in, NUM_SRC*REG_AW, ID source addresses; operand i is in bits [i*REG_AW +: REG_AW].
- id_rd, in, REG_AW, ID destination.
- id_regwrite, in, 1, ID instruction writes id_rd.
- id_is_load, in, 1, ID instruction is a load.
- flush, in, 1, kill the ID instruction (branch/jump redirect).
- mem_busy, in, 1, data memory has not completed this cycle.
- fwd_sel, out, NUM_SRC*SEL_W, per-EX-operand bypass select: 0 = register file, k = stage k.
- id_stall, out, 1, hold PC and IF/ID.
- pipe_freeze, out, 1, hold every pipeline register.
- stall_count, out, CNT_W, saturating count of cycles with id_stall high.

## Operation
- Internal entries e[0..FWD_STAGES], each {we, rd, ld}. e[0] is EX. ex_rs[0..NUM_SRC-1] holds the source addresses of the EX instruction.
- Forward select for operand i: smallest k in 1..FWD_STAGES with e[k].we, e[k].rd≠0 and e[k].rd==ex_rs[i]. Youngest wins. No match gives 0.
- Load-use hazard: any i and any k in 0..LOAD_STAGE-2 with id_valid, id_rs[i]≠0, e[k].we, e[k].ld and e[k].rd==id_rs[i]. With LOAD_STAGE=1 the hazard never fires.
- id_stall = hazard | mem_busy.
- pipe_freeze = mem_busy.
- Update on each clock edge:
  - mem_busy=1: all state holds, including ex_rs. flush is ignored; the core holds flush until the freeze ends.
  - Else, for k≥1: e[k] ← e[k-1].
  - Else, if hazard, flush or !id_valid: e[0] ← bubble {0,0,0} and ex_rs ← 0.
  - Else: e[0] ← {id_regwrite, id_rd, id_is_load} and ex_rs ← id_rs.
- A write to rd=0 is captured but never forwarded.
- stall_count increments by 1 each cycle id_stall=1 and saturates at all-ones.

## Timing
- Reset (asynchronous assert, synchronous release): all entries {0,0,0}, ex_rs=0, stall_count=0.
  - fwd_sel=0 immediately.
  - id_stall = pipe_freeze = mem_busy.
- fwd_sel is a function of registered state only; it has no combinational input path.
- id_stall and pipe_freeze are combinational from id_* inputs, mem_busy and state. They are valid in the same cycle.
- A load at e[0] followed by a dependent instruction in ID stalls for exactly LOAD_STAGE-1 cycles when mem_busy=0.
  - Default configuration: 1 bubble. The dependent instruction then sees fwd_sel=LOAD_STAGE.
- A producer one cycle ahead gives fwd_sel=1. Two cycles ahead gives fwd_sel=2.
- Reset mid-freeze clears all state. Nothing survives the reset.

## Test plan
- ALU forwarding: issue add x5, then sub using x5 as rs1 the next cycle, then an instruction using x5 one cycle later → with sub in EX, operand 0 fwd_sel=1; for the following instruction fwd_sel=2; id_stall never set.
- Double hazard: two back-to-back writes to x7, then a reader of x7 → fwd_sel=1 (youngest wins, not 2).
- Load-use: lw x3, then add x4,x3,x3 → id_stall=1 for exactly 1 cycle and e[0] bubbles. Next cycle add enters EX with both fwd_sel=2. stall_count=1.
- x0 and flush: addi x0, then a reader of x0 → fwd_sel=0. lw x9 then flush with a reader of x9 in ID → bubble inserted and no stall on the next instruction.
- Memory freeze: lw x3 then add x5,x3,x0, holding mem_busy=1 for 3 cycles during the load-use bubble → state frozen, id_stall=pipe_freeze=1 for 3 cycles, stall_count=4 total, forwarding resumes with fwd_sel=2.
- Parameter sweep: NUM_SRC=3, FWD_STAGES=4, LOAD_STAGE=3 → load-use stall is 2 cycles and a producer 4 ahead gives fwd_sel=4. With CNT_W=4, id_stall held for 20 cycles → stall_count saturates at 15. rst_n pulled low mid-stall → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use/memory hazard control for the RV32I pipeline.
// A shadow pipeline of {we, rd, ld} entries mirrors EX through the last forwarding stage.
module fwd_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_regwrite,
    input  logic                        id_is_load,
    input  logic                        flush,
    input  logic                        mem_busy,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        id_stall,
    output logic                        pipe_freeze,
    output logic [CNT_W-1:0]            stall_count
);

    logic [FWD_STAGES:0] e_we;
    logic [FWD_STAGES:0] e_ld;
    logic [REG_AW-1:0]   e_rd  [FWD_STAGES+1];
    logic [REG_AW-1:0]   ex_rs [NUM_SRC];
    logic                hazard;
    logic                insert_bubble;
    logic                unused_ld;

    // The oldest entry's load flag is only ever shifted out.
    assign unused_ld = e_ld[FWD_STAGES];

    // Scan from the oldest stage down so the youngest matching producer wins.
    always_comb begin
        fwd_sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
                if (e_we[k] && (e_rd[k] != '0) && (e_rd[k] == ex_rs[i])) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = 0; k + 1 < LOAD_STAGE; k++) begin
                if (id_valid && (id_rs[i*REG_AW +: REG_AW] != '0) && e_we[k] && e_ld[k]
                    && (e_rd[k] == id_rs[i*REG_AW +: REG_AW])) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign id_stall      = hazard | mem_busy;
    assign pipe_freeze   = mem_busy;
    assign insert_bubble = hazard | flush | ~id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_we <= '0;
            e_ld <= '0;
            for (int unsigned k = 0; k <= FWD_STAGES; k++) e_rd[k] <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) ex_rs[i] <= '0;
        end else if (!mem_busy) begin
            for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                e_we[k] <= e_we[k-1];
                e_ld[k] <= e_ld[k-1];
                e_rd[k] <= e_rd[k-1];
            end
            if (insert_bubble) begin
                e_we[0] <= 1'b0;
                e_ld[0] <= 1'b0;
                e_rd[0] <= '0;
                for (int unsigned i = 0; i < NUM_SRC; i++) ex_rs[i] <= '0;
            end else begin
                e_we[0] <= id_regwrite;
                e_ld[0] <= id_is_load;
                e_rd[0] <= id_rd;
                for (int unsigned i = 0; i < NUM_SRC; i++) ex_rs[i] <= id_rs[i*REG_AW +: REG_AW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (id_stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: default configuration plus a wider sweep instance (3 sources, 4 stages, 4-bit counter).
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n, rst_b;
    int          errors = 0;
    int          checks = 0;

    // Default instance
    logic        a_valid, a_rw, a_ld, a_flush, a_busy;
    logic [9:0]  a_rs;
    logic [4:0]  a_rd;
    logic [3:0]  a_fwd;
    logic        a_stall, a_freeze;
    logic [31:0] a_cnt;

    // Sweep instance
    logic        b_valid, b_rw, b_ld, b_flush, b_busy;
    logic [14:0] b_rs;
    logic [4:0]  b_rd;
    logic [8:0]  b_fwd;
    logic        b_stall, b_freeze;
    logic [3:0]  b_cnt;

    always #5 clk = ~clk;

    fwd_hazard_unit dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(a_valid), .id_rs(a_rs), .id_rd(a_rd),
        .id_regwrite(a_rw), .id_is_load(a_ld), .flush(a_flush), .mem_busy(a_busy),
        .fwd_sel(a_fwd), .id_stall(a_stall), .pipe_freeze(a_freeze), .stall_count(a_cnt)
    );

    fwd_hazard_unit #(
        .REG_AW(5), .NUM_SRC(3), .FWD_STAGES(4), .LOAD_STAGE(3), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .id_valid(b_valid), .id_rs(b_rs), .id_rd(b_rd),
        .id_regwrite(b_rw), .id_is_load(b_ld), .flush(b_flush), .mem_busy(b_busy),
        .fwd_sel(b_fwd), .id_stall(b_stall), .pipe_freeze(b_freeze), .stall_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic rw, input logic ld);
        a_valid = v; a_rs = {rs1, rs0}; a_rd = rd; a_rw = rw; a_ld = ld;
    endtask

    task automatic set_b(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic rw, input logic ld);
        b_valid = v; b_rs = {rs2, rs1, rs0}; b_rd = rd; b_rw = rw; b_ld = ld;
    endtask

    initial begin
        rst_n = 1'b0; rst_b = 1'b0;
        set_a(0, 0, 0, 0, 0, 0); a_flush = 0; a_busy = 0;
        set_b(0, 0, 0, 0, 0, 0, 0); b_flush = 0; b_busy = 0;
        #2;
        chk("rst_fwd", a_fwd, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_freeze", a_freeze, 0);
        chk("rst_cnt", a_cnt, 0);
        a_busy = 1; #1;
        chk("rst_busy_stall", a_stall, 1);
        chk("rst_busy_freeze", a_freeze, 1);
        a_busy = 0; rst_n = 1; rst_b = 1;
        cyc();

        // ALU forwarding: add x5; sub x6,x5,x1; or x8,x5,x0
        set_a(1, 1, 2, 5, 1, 0); #3; chk("alu_a_stall", a_stall, 0); cyc();
        set_a(1, 5, 1, 6, 1, 0); #3; chk("alu_b_fwd", a_fwd, 4'b0000); chk("alu_b_stall", a_stall, 0); cyc();
        set_a(1, 5, 0, 8, 1, 0); #3; chk("alu_fwd1", a_fwd, 4'b0001); chk("alu_c_stall", a_stall, 0); cyc();
        set_a(0, 0, 0, 0, 0, 0); #3; chk("alu_fwd2", a_fwd, 4'b0010); chk("alu_d_stall", a_stall, 0); cyc();

        // Double hazard: two writes to x7, then reader of x7 on both operands
        set_a(1, 0, 0, 7, 1, 0); #3; chk("dbl_pre_fwd", a_fwd, 4'b0000); cyc();
        set_a(1, 0, 0, 7, 1, 0); cyc();
        set_a(1, 7, 7, 10, 1, 0); cyc();
        set_a(0, 0, 0, 0, 0, 0); #3; chk("dbl_youngest", a_fwd, 4'b0101); cyc();

        // Load-use: lw x3; add x4,x3,x3
        set_a(1, 2, 0, 3, 1, 1); #3; chk("lu_lw_stall", a_stall, 0); cyc();
        set_a(1, 3, 3, 4, 1, 0); #3;
        chk("lu_stall", a_stall, 1); chk("lu_freeze", a_freeze, 0); chk("lu_cnt0", a_cnt, 0); cyc();
        #3; chk("lu_release", a_stall, 0); chk("lu_bubble_fwd", a_fwd, 4'b0000); chk("lu_cnt1", a_cnt, 1); cyc();
        set_a(0, 0, 0, 0, 0, 0); #3; chk("lu_fwd2", a_fwd, 4'b1010); chk("lu_cnt_hold", a_cnt, 1); cyc();

        // x0 is never forwarded
        set_a(1, 1, 0, 0, 1, 0); cyc();
        set_a(1, 0, 0, 11, 1, 0); cyc();
        set_a(0, 0, 0, 0, 0, 0); #3; chk("x0_fwd", a_fwd, 4'b0000); cyc();

        // lw x9, then dependent reader killed by flush
        set_a(1, 1, 0, 9, 1, 1); cyc();
        set_a(1, 9, 0, 12, 1, 0); a_flush = 1; #3; chk("fl_hz_stall", a_stall, 1); cyc();
        a_flush = 0; set_a(1, 9, 9, 13, 1, 0); #3;
        chk("fl_next_stall", a_stall, 0); chk("fl_bubble_fwd", a_fwd, 4'b0000); cyc();
        set_a(0, 0, 0, 0, 0, 0); #3; chk("fl_fwd2", a_fwd, 4'b1010); chk("fl_cnt", a_cnt, 2); cyc();

        // Flush of an independent producer must bubble it
        set_a(1, 0, 0, 14, 1, 0); a_flush = 1; cyc();
        a_flush = 0; set_a(1, 14, 14, 15, 1, 0); #3; chk("fl2_stall", a_stall, 0); cyc();
        set_a(0, 0, 0, 0, 0, 0); #3; chk("fl2_killed_fwd", a_fwd, 4'b0000); cyc();

        // Memory freeze during the load-use bubble: lw x3; add x5,x3,x0
        set_a(1, 1, 0, 3, 1, 1); cyc();
        set_a(1, 3, 0, 5, 1, 0); #3; chk("mf_hz_stall", a_stall, 1); chk("mf_hz_freeze", a_freeze, 0); cyc();
        a_busy = 1;
        for (int n = 0; n < 3; n++) begin
            #3;
            chk("mf_stall", a_stall, 1); chk("mf_freeze", a_freeze, 1); chk("mf_fwd", a_fwd, 4'b0000);
            cyc();
        end
        a_busy = 0; #3; chk("mf_release", a_stall, 0); chk("mf_cnt", a_cnt, 6); cyc();
        set_a(0, 0, 0, 0, 0, 0); #3; chk("mf_fwd2", a_fwd, 4'b0010); chk("mf_cnt_hold", a_cnt, 6); cyc();

        // Sweep instance: load-use stalls for two cycles, then forwards from stage 3
        set_b(1, 0, 0, 0, 3, 1, 1); cyc();
        set_b(1, 3, 0, 0, 4, 1, 0); #3; chk("sw_lu_stall1", b_stall, 1); cyc();
        #3; chk("sw_lu_stall2", b_stall, 1); cyc();
        #3; chk("sw_lu_release", b_stall, 0); chk("sw_lu_cnt", b_cnt, 2); cyc();
        set_b(0, 0, 0, 0, 0, 0, 0); #3; chk("sw_lu_fwd3", b_fwd, 9'h003); cyc();

        // Producer four ahead: addi x20, three idle cycles, reader on operand 2
        set_b(1, 0, 0, 0, 20, 1, 0); cyc();
        set_b(0, 0, 0, 0, 0, 0, 0); repeat (3) cyc();
        set_b(1, 0, 0, 20, 21, 1, 0); cyc();
        set_b(0, 0, 0, 0, 0, 0, 0); b_busy = 1; #3;
        chk("sw_fwd4", b_fwd, 9'h100); chk("sw_busy_stall", b_stall, 1); chk("sw_cnt_pre", b_cnt, 2); cyc();

        // Hold id_stall for 20 cycles in total: counter saturates at 15 and state stays frozen
        repeat (12) cyc();
        #3; chk("sw_cnt_sat", b_cnt, 15); cyc();
        repeat (6) cyc();
        #3; chk("sw_cnt_hold", b_cnt, 15); chk("sw_frozen_fwd", b_fwd, 9'h100);

        // Asynchronous reset in the middle of the freeze
        rst_b = 0; #1;
        chk("sw_rst_fwd", b_fwd, 0); chk("sw_rst_cnt", b_cnt, 0);
        chk("sw_rst_stall", b_stall, 1); chk("sw_rst_freeze", b_freeze, 1);
        b_busy = 0; #1;
        chk("sw_rst_stall_idle", b_stall, 0);
        cyc(); rst_b = 1; cyc();
        #3; chk("sw_post_rst_fwd", b_fwd, 0); chk("sw_post_rst_cnt", b_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
